logic_unit_seq: RTL and testbench

Parametrised, multi-cycle bitwise logic unit for the ALU datapath, the successor to the fixed 64-bit combinational AND. It supports four operations (AND, OR, XOR, ANDN) on WIDTH-bit operands and processes them SLICE bits per cycle under a start/done handshake. It produces a registered result plus zero and sign flags for the condition-code logic. It sits beside the adder in the execute stage and trades latency for a narrow logic datapath.

---
 rtl/logic_pkg.sv | 18 +
 rtl/logic_unit_seq_if.sv | 28 ++
 rtl/logic_slice.sv | 24 ++
 rtl/logic_unit_seq.sv | 99 +++++++++
 tb/tb_logic_unit_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic unit: op encoding and FSM state type.
// The op encoding is also used by the ALU decoder.
package logic_pkg;

  typedef logic [1:0] logic_op_t;

  localparam logic_op_t OP_AND  = 2'b00;
  localparam logic_op_t OP_OR   = 2'b01;
  localparam logic_op_t OP_XOR  = 2'b10;
  localparam logic_op_t OP_ANDN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lus_state_t;

endpackage

// File: rtl/logic_unit_seq_if.sv
// Request/result bundle between the execute stage and the sequential logic unit.
import logic_pkg::*;

// start is honoured only while the unit is idle or presenting done; done is a
// one-cycle pulse, and y/zf/sf stay valid from that pulse until the next one.
interface logic_unit_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic_op_t        op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             zf;
  logic             sf;

  modport master (
    output start, op, a, b,
    input  busy, done, y, zf, sf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, y, zf, sf
  );
endinterface

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise operator, shared across all cycles of an operation.
import logic_pkg::*;

module logic_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic_op_t        op,
  output logic [SLICE-1:0] y_s
);

  always_comb begin
    y_s = '0;
    case (op)
      OP_AND:  y_s = a_s & b_s;
      OP_OR:   y_s = a_s | b_s;
      OP_XOR:  y_s = a_s ^ b_s;
      OP_ANDN: y_s = a_s & ~b_s;
      default: y_s = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: WIDTH-bit AND/OR/XOR/ANDN computed SLICE bits
// per cycle, with registered result and zero/sign flags.
import logic_pkg::*;

module logic_unit_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  logic_unit_seq_if.slave        bus,
  output lus_state_t             state
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  lus_state_t       state_q, state_d;
  logic [CW-1:0]    cnt;
  logic_op_t        op_q;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_next, y_q;
  logic             zacc, zf_q, sf_q;
  logic [SLICE-1:0] a_s, b_s, y_s;
  logic             accept, last, slice_zero;
  int               off;

  assign accept     = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last       = (cnt == CW'(N - 1));
  assign slice_zero = ~|y_s;

  always_comb begin
    off      = int'(cnt) * SLICE;
    a_s      = a_q[off +: SLICE];
    b_s      = b_q[off +: SLICE];
    acc_next = acc;
    acc_next[off +: SLICE] = y_s;
  end

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a_s (a_s),
    .b_s (b_s),
    .op  (op_q),
    .y_s (y_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_BUSY;
      ST_BUSY: if (last) state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // y/zf/sf load only on the final slice, so partial results never appear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      op_q <= OP_AND;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      zacc <= 1'b0;
      y_q  <= '0;
      zf_q <= 1'b0;
      sf_q <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= bus.op;
      a_q  <= bus.a;
      b_q  <= bus.b;
      acc  <= '0;
      zacc <= 1'b1;
    end else if (state_q == ST_BUSY) begin
      acc  <= acc_next;
      zacc <= zacc & slice_zero;
      cnt  <= cnt + 1'b1;
      if (last) begin
        y_q  <= acc_next;
        zf_q <= zacc & slice_zero;
        sf_q <= acc_next[WIDTH-1];
      end
    end
  end

  assign bus.busy = (state_q == ST_BUSY);
  assign bus.done = (state_q == ST_DONE);
  assign bus.y    = y_q;
  assign bus.zf   = zf_q;
  assign bus.sf   = sf_q;
  assign state    = state_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq at SLICE=16 (N=4) and SLICE=64 (N=1).
import logic_pkg::*;

module tb_logic_unit_seq;

  localparam int W  = 64;
  localparam int EW = 98;  // {done_cycle[31:0], sf, zf, y[63:0]}

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic_unit_seq_if #(.WIDTH(W)) bus16 ();
  logic_unit_seq_if #(.WIDTH(W)) bus64 ();
  lus_state_t state16, state64;

  logic_unit_seq #(.WIDTH(W), .SLICE(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16.slave), .state(state16)
  );
  logic_unit_seq #(.WIDTH(W), .SLICE(64)) dut64 (
    .clk(clk), .rst(rst), .bus(bus64.slave), .state(state64)
  );

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q16[$];
  logic [EW-1:0] exp_q64[$];
  int busy_run16 = 0;
  int busy_run64 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_result(input string tag, input logic [EW-1:0] e, input logic [63:0] y,
                              input logic zf, input logic sf, input int busy_run, input int n);
    chk({tag, "_y"}, y, e[63:0]);
    chk({tag, "_zf"}, 64'(zf), 64'(e[64]));
    chk({tag, "_sf"}, 64'(sf), 64'(e[65]));
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(e[97:66]));
    chk({tag, "_busy_cycles"}, 64'(busy_run), 64'(n));
  endtask

  // Monitors: pop and compare whenever a unit presents done.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) busy_run16 = 0;
    else begin
      chk("dut16_busy_done_excl", 64'(bus16.busy & bus16.done), 64'd0);
      if (bus16.busy) busy_run16++;
      if (bus16.done) begin
        if (exp_q16.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut16_unexpected_done actual=done expected=no_done (cycle %0d)", cyc);
        end else begin
          e = exp_q16.pop_front();
          check_result("dut16", e, bus16.y, bus16.zf, bus16.sf, busy_run16, 4);
        end
        busy_run16 = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) busy_run64 = 0;
    else begin
      chk("dut64_busy_done_excl", 64'(bus64.busy & bus64.done), 64'd0);
      if (bus64.busy) busy_run64++;
      if (bus64.done) begin
        if (exp_q64.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut64_unexpected_done actual=done expected=no_done (cycle %0d)", cyc);
        end else begin
          e = exp_q64.pop_front();
          check_result("dut64", e, bus64.y, bus64.zf, bus64.sf, busy_run64, 1);
        end
        busy_run64 = 0;
      end
    end
  end

  function automatic int qsize(input int sel);
    return (sel == 16) ? exp_q16.size() : exp_q64.size();
  endfunction

  // Called at a negedge; the request is accepted at the following posedge.
  // With junk set, start stays high with other operands for the whole busy window.
  task automatic issue(input int sel, input logic_op_t op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] ey, input bit junk);
    int n;
    logic [EW-1:0] e;
    n = W / sel;
    e = {32'(cyc + 1 + n), ey[63], (ey == 64'd0), ey};
    if (sel == 16) begin
      bus16.start = 1'b1; bus16.op = op; bus16.a = a; bus16.b = b;
      exp_q16.push_back(e);
    end else begin
      bus64.start = 1'b1; bus64.op = op; bus64.a = a; bus64.b = b;
      exp_q64.push_back(e);
    end
    @(negedge clk);
    if (junk) begin
      for (int i = 0; i < n; i++) begin
        if (sel == 16) begin
          bus16.start = 1'b1; bus16.op = logic_op_t'(i);
          bus16.a = 64'h5A5A_0000_0000_0001 + 64'(i); bus16.b = 64'h0123_4567_89AB_CDEF;
        end else begin
          bus64.start = 1'b1; bus64.op = logic_op_t'(i);
          bus64.a = 64'h5A5A_0000_0000_0001 + 64'(i); bus64.b = 64'h0123_4567_89AB_CDEF;
        end
        @(negedge clk);
      end
    end
    if (sel == 16) bus16.start = 1'b0;
    else           bus64.start = 1'b0;
  endtask

  task automatic drain(input int sel);
    int k;
    k = 0;
    while (qsize(sel) != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending_results", 64'(qsize(sel)), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_done16();
    int k;
    k = 0;
    while (!bus16.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done16_timeout", 64'(bus16.done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus16.start = 1'b0; bus16.op = OP_AND; bus16.a = '0; bus16.b = '0;
    bus64.start = 1'b0; bus64.op = OP_AND; bus64.a = '0; bus64.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy16", 64'(bus16.busy), 64'd0);
    chk("reset_done16", 64'(bus16.done), 64'd0);
    chk("reset_y16", bus16.y, 64'd0);
    chk("reset_flags16", 64'({bus16.zf, bus16.sf}), 64'd0);
    chk("reset_state16", 64'(state16), 64'(ST_IDLE));
    chk("reset_y64", bus64.y, 64'd0);
    chk("reset_state64", 64'(state64), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // AND of complementary patterns gives zero
    issue(16, OP_AND, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 64'h0, 1'b0);
    drain(16);

    issue(16, OP_XOR, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 64'h1DD99DD11DD99DD1, 1'b0);
    drain(16);

    // Back-to-back: second start issued in the DONE cycle of the first
    issue(16, OP_OR, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    wait_done16();
    issue(16, OP_ANDN, 64'hFFFFFFFFFFFFFFFF, 64'h00000000000000FF, 64'hFFFFFFFFFFFFFF00, 1'b0);
    drain(16);

    issue(16, OP_ANDN, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1'b0);
    drain(16);

    // start held while busy with other operands must be ignored
    issue(16, OP_AND, 64'hFFFF0000FFFF0000, 64'hF0F0F0F0F0F0F0F0, 64'hF0F00000F0F00000, 1'b1);
    drain(16);
    repeat (6) @(negedge clk);

    // Reset during an operation: outputs clear and no done follows
    issue(16, OP_XOR, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 64'h1DD99DD11DD99DD1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    exp_q16.delete();
    #1;
    chk("midreset_busy", 64'(bus16.busy), 64'd0);
    chk("midreset_done", 64'(bus16.done), 64'd0);
    chk("midreset_y", bus16.y, 64'd0);
    chk("midreset_flags", 64'({bus16.zf, bus16.sf}), 64'd0);
    chk("midreset_state", 64'(state16), 64'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(16, OP_AND, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    drain(16);

    // Single-slice configuration
    issue(64, OP_XOR, 64'h00000000000000FF, 64'h00000000000000FF, 64'h0, 1'b0);
    drain(64);
    issue(64, OP_OR, 64'h8000000000000000, 64'h0000000000000001, 64'h8000000000000001, 1'b0);
    drain(64);
    issue(64, OP_ANDN, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'hF0F00000F0F00000, 1'b1);
    drain(64);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
